// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: multi-cycle signed multiply/divide unit, one bit per cycle
module multdiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t             state;
    logic [CW-1:0]      counter;
    logic [2*WIDTH-1:0] work;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               neg, b_zero, is_div;
    logic               start;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_s;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   quo, res_next;
    logic               exc_next;
    // Shared datapath: shift-add multiply step, restoring divide step and the sign fix-up
    always_comb begin
        start    = ctrl_MULT | ctrl_DIV;
        abs_a    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        abs_b    = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        mul_next = {work[2*WIDTH-2:0], 1'b0} + (mag_b[WIDTH-1] ? {{WIDTH{1'b0}}, mag_a} : '0);
        diff     = {1'b0, work[2*WIDTH-2:WIDTH-1]} - {1'b0, mag_b};
        div_next = diff[WIDTH] ? {work[2*WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
        prod_s   = neg ? -work : work;
        quo      = neg ? -work[WIDTH-1:0] : work[WIDTH-1:0];
        res_next = is_div ? (b_zero ? '0 : quo) : prod_s[WIDTH-1:0];
        exc_next = is_div ? (b_zero | (!neg & work[WIDTH-1]))
                          : !(&prod_s[2*WIDTH-1:WIDTH-1] | ~|prod_s[2*WIDTH-1:WIDTH-1]);
    end
    // Sequencer: a start in any state restarts; otherwise iterate WIDTH times, then finish
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            counter        <= '0;
            work           <= '0;
            mag_a          <= '0;
            mag_b          <= '0;
            neg            <= 1'b0;
            b_zero         <= 1'b0;
            is_div         <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (start) begin
                state   <= ctrl_MULT ? MUL : DIV;
                is_div  <= !ctrl_MULT;
                counter <= '0;
                mag_a   <= abs_a;
                mag_b   <= abs_b;
                neg     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                b_zero  <= data_operandB == '0;
                work    <= ctrl_MULT ? '0 : {{WIDTH{1'b0}}, abs_a};
                busy    <= 1'b1;
            end else begin
                case (state)
                    MUL: begin
                        work    <= mul_next;
                        mag_b   <= mag_b << 1;
                        counter <= counter + 1'b1;
                        state   <= counter == CW'(WIDTH - 1) ? DONE : MUL;
                    end
                    DIV: begin
                        work    <= div_next;
                        counter <= counter + 1'b1;
                        state   <= counter == CW'(WIDTH - 1) ? DONE : DIV;
                    end
                    DONE: begin
                        data_result    <= res_next;
                        data_exception <= exc_next;
                        data_resultRDY <= 1'b1;
                        state          <= IDLE;
                    end
                    default: busy <= 1'b0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl: directed self-checking bench for multdiv_ctrl
module tb_multdiv_ctrl;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;
    int          n_checks = 0;
    int          n_fail = 0;

    multdiv_ctrl #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .data_result(data_result), .data_exception(data_exception),
        .data_resultRDY(data_resultRDY), .busy(busy)
    );

    always #5 clock = ~clock;

    // Entered and left at 1 time unit after a rising edge; the edge inside is the start edge
    task automatic do_start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_rdy(output int cyc);
        cyc = 0;
        do begin
            @(posedge clock);
            #1;
            cyc++;
            data_operandA = $urandom;
        end while (!data_resultRDY && cyc < 60);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) begin @(posedge clock); #1; end
        reset = 1'b0;
        repeat (5) begin
            @(posedge clock);
            #1;
            n_checks += 4;
            if (data_result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", data_result); end
            if (data_exception !== 1'b0) begin n_fail++; $display("FAIL reset_exc got %b want 0", data_exception); end
            if (data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got %b want 0", data_resultRDY); end
            if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        end
    endtask

    task automatic test_ops(input logic d);
        logic [31:0] va[3], vb[3], vr[3];
        logic        ve[3];
        int          c;
        if (!d) begin
            va = '{32'd7, 32'h00010000, 32'h80000000};
            vb = '{32'hFFFFFFFA, 32'h00010000, 32'd1};
            vr = '{32'hFFFFFFD6, 32'h0, 32'h80000000};
            ve = '{1'b0, 1'b1, 1'b0};
        end else begin
            va = '{32'hFFFFFFF9, 32'd100, 32'h80000000};
            vb = '{32'd2, 32'd0, 32'hFFFFFFFF};
            vr = '{32'hFFFFFFFD, 32'h0, 32'h80000000};
            ve = '{1'b0, 1'b1, 1'b1};
        end
        for (int i = 0; i < 3; i++) begin
            do_start(!d, d, va[i], vb[i]);
            n_checks++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL op%0d_%0d_busy got %b want 1", d, i, busy); end
            wait_rdy(c);
            n_checks += 3;
            if (c != 33) begin n_fail++; $display("FAIL op%0d_%0d_latency got %0d want 33", d, i, c); end
            if (data_result !== vr[i]) begin n_fail++; $display("FAIL op%0d_%0d_result got %h want %h", d, i, data_result, vr[i]); end
            if (data_exception !== ve[i]) begin n_fail++; $display("FAIL op%0d_%0d_exc got %b want %b", d, i, data_exception, ve[i]); end
            @(posedge clock);
            #1;
            n_checks += 3;
            if (data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL op%0d_%0d_rdy_pulse got %b want 0", d, i, data_resultRDY); end
            if (busy !== 1'b0) begin n_fail++; $display("FAIL op%0d_%0d_busy_after got %b want 0", d, i, busy); end
            if (data_result !== vr[i]) begin n_fail++; $display("FAIL op%0d_%0d_hold got %h want %h", d, i, data_result, vr[i]); end
        end
    endtask

    task automatic test_abort;
        int   c;
        logic seen = 1'b0;
        do_start(1'b0, 1'b1, 32'd50, 32'd5);
        repeat (9) begin @(posedge clock); #1; seen |= data_resultRDY; end
        do_start(1'b1, 1'b0, 32'd3, 32'd4);
        wait_rdy(c);
        n_checks += 4;
        if (seen) begin n_fail++; $display("FAIL abort_early_rdy got 1 want 0"); end
        if (c != 33) begin n_fail++; $display("FAIL abort_latency got %0d want 33", c); end
        if (data_result !== 32'd12) begin n_fail++; $display("FAIL abort_result got %h want %h", data_result, 32'd12); end
        if (data_exception !== 1'b0) begin n_fail++; $display("FAIL abort_exc got %b want 0", data_exception); end
        seen = 1'b0;
        repeat (40) begin @(posedge clock); #1; seen |= data_resultRDY; end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL abort_extra_rdy got 1 want 0"); end
    endtask

    task automatic test_collision;
        int c;
        do_start(1'b1, 1'b1, 32'd9, 32'd3);
        wait_rdy(c);
        n_checks += 2;
        if (c != 33) begin n_fail++; $display("FAIL collide_latency got %0d want 33", c); end
        if (data_result !== 32'd27) begin n_fail++; $display("FAIL collide_result got %h want %h", data_result, 32'd27); end
    endtask

    task automatic test_reset_mid;
        int   c;
        logic seen = 1'b0;
        do_start(1'b1, 1'b0, 32'd1234, 32'd5);
        repeat (14) begin @(posedge clock); #1; end
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
            data_operandA = $urandom;
            data_operandB = $urandom;
            seen |= data_resultRDY;
        end
        n_checks += 4;
        if (seen) begin n_fail++; $display("FAIL rstmid_rdy got 1 want 0"); end
        if (data_result !== 32'h0) begin n_fail++; $display("FAIL rstmid_result got %h want 0", data_result); end
        if (data_exception !== 1'b0) begin n_fail++; $display("FAIL rstmid_exc got %b want 0", data_exception); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
        do_start(1'b1, 1'b0, 32'd5, 32'd5);
        wait_rdy(c);
        n_checks += 3;
        if (c != 33) begin n_fail++; $display("FAIL rstmid_latency got %0d want 33", c); end
        if (data_result !== 32'd25) begin n_fail++; $display("FAIL rstmid_result2 got %h want %h", data_result, 32'd25); end
        if (data_exception !== 1'b0) begin n_fail++; $display("FAIL rstmid_exc2 got %b want 0", data_exception); end
    endtask

    initial begin
        #1;
        test_reset;
        test_ops(1'b0);
        test_ops(1'b1);
        test_abort;
        test_collision;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
